// File: rtl/exe_div_ctrl.sv
// Iterative 32-bit restoring divider for the EXE stage. Handles div.w/mod.w/div.wu/mod.wu
// in a fixed 32 cycles, with a one-entry result that is held until the pipeline acknowledges it.
module exe_div_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_req,
    input  logic        div_signed,
    input  logic        div_rem,
    input  logic [31:0] div_src1,
    input  logic [31:0] div_src2,
    input  logic        div_ack,
    input  logic        div_cancel,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] div_result,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q;
    logic [31:0] divisor_q;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dividend_raw_q;
    logic        rem_sel_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        div_zero_q;
    logic [31:0] result_q;

    logic        accept;
    logic        last_step;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic        take;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [31:0] final_res;

    assign accept    = (state_q == S_IDLE) && div_req && !div_cancel;
    assign last_step = (state_q == S_BUSY) && (cnt_q == 6'd31);

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; cancel outranks every other transition
    always_comb begin
        state_d = state_q;
        if (div_cancel) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (div_req) state_d = S_BUSY;
                S_BUSY:  if (cnt_q == 6'd31) state_d = S_DONE;
                S_DONE:  if (div_ack) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        div_busy  = 1'b0;
        div_done  = 1'b0;
        dbg_state = state_q;
        case (state_q)
            S_BUSY:  div_busy = 1'b1;
            S_DONE:  div_done = 1'b1;
            default: ;
        endcase
    end

    // One restoring step: shift the next dividend bit into the partial remainder
    always_comb begin
        rem_sh = {rem_q, quo_q[31]};
        diff   = rem_sh - {1'b0, divisor_q};
        take   = !diff[32];
        rem_nx = take ? diff[31:0] : rem_sh[31:0];
        quo_nx = {quo_q[30:0], take};
    end

    // Divide-by-zero bypasses the magnitude datapath entirely; overflow falls out naturally
    always_comb begin
        q_fix = q_neg_q ? (32'd0 - quo_nx) : quo_nx;
        r_fix = r_neg_q ? (32'd0 - rem_nx) : rem_nx;
        if (div_zero_q) begin
            final_res = rem_sel_q ? dividend_raw_q : 32'hFFFF_FFFF;
        end else begin
            final_res = rem_sel_q ? r_fix : q_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q          <= 6'd0;
            divisor_q      <= 32'd0;
            quo_q          <= 32'd0;
            rem_q          <= 32'd0;
            dividend_raw_q <= 32'd0;
            rem_sel_q      <= 1'b0;
            q_neg_q        <= 1'b0;
            r_neg_q        <= 1'b0;
            div_zero_q     <= 1'b0;
            result_q       <= 32'd0;
        end else if (accept) begin
            cnt_q          <= 6'd0;
            quo_q          <= (div_signed && div_src1[31]) ? (32'd0 - div_src1) : div_src1;
            divisor_q      <= (div_signed && div_src2[31]) ? (32'd0 - div_src2) : div_src2;
            rem_q          <= 32'd0;
            dividend_raw_q <= div_src1;
            rem_sel_q      <= div_rem;
            q_neg_q        <= div_signed && (div_src1[31] ^ div_src2[31]);
            r_neg_q        <= div_signed && div_src1[31];
            div_zero_q     <= (div_src2 == 32'd0);
        end else if (state_q == S_BUSY && !div_cancel) begin
            cnt_q <= cnt_q + 6'd1;
            quo_q <= quo_nx;
            rem_q <= rem_nx;
            if (last_step) begin
                result_q <= final_res;
            end
        end else if (div_cancel) begin
            cnt_q <= 6'd0;
        end
    end

    assign div_result = result_q;

endmodule

// File: tb/tb_exe_div_ctrl.sv
// Directed bench for exe_div_ctrl: a table of divide vectors with hand-computed results,
// followed by cancel, acknowledge-stall and mid-operation reset sequences.
module tb_exe_div_ctrl;

    logic        clk;
    logic        resetn;
    logic        div_req;
    logic        div_signed;
    logic        div_rem;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        div_ack;
    logic        div_cancel;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_result;
    logic [1:0]  dbg_state;

    int checks;
    int failures;

    typedef struct {
        logic        sgn;
        logic        rem;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    exe_div_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_req    (div_req),
        .div_signed (div_signed),
        .div_rem    (div_rem),
        .div_src1   (div_src1),
        .div_src2   (div_src2),
        .div_ack    (div_ack),
        .div_cancel (div_cancel),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .div_result (div_result),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then scramble the operand inputs
    task automatic start_op(input logic sgn, input logic rem, input logic [31:0] a, input logic [31:0] b);
        div_signed = sgn;
        div_rem    = rem;
        div_src1   = a;
        div_src2   = b;
        div_req    = 1'b1;
        tick();
        div_req    = 1'b0;
        div_src1   = $urandom;
        div_src2   = $urandom;
        div_signed = ~sgn;
        div_rem    = ~rem;
        check("accept_busy", {31'd0, div_busy}, 32'd1);
        check("accept_state", {30'd0, dbg_state}, 32'd1);
    endtask

    // Count edges from acceptance until div_done, bounded
    task automatic wait_done(input string name, input logic [31:0] exp);
        int n;
        n = 0;
        do begin
            tick();
            n++;
            if (n < 32 && div_done) break;
        end while (!div_done && n < 40);
        check({name, "_latency"}, n, 32);
        check({name, "_done"}, {31'd0, div_done}, 32'd1);
        check({name, "_result"}, div_result, exp);
    endtask

    task automatic ack_op();
        div_ack = 1'b1;
        tick();
        div_ack = 1'b0;
        check("ack_idle_done", {31'd0, div_done}, 32'd0);
        check("ack_idle_busy", {31'd0, div_busy}, 32'd0);
    endtask

    initial begin
        int seen_done;
        logic [31:0] held;
        checks     = 0;
        failures   = 0;
        resetn     = 1'b0;
        div_req    = 1'b0;
        div_signed = 1'b0;
        div_rem    = 1'b0;
        div_src1   = 32'd0;
        div_src2   = 32'd0;
        div_ack    = 1'b0;
        div_cancel = 1'b0;

        vecs[0]  = '{1'b0, 1'b0, 32'd100,        32'd7,          32'h0000_000E};
        vecs[1]  = '{1'b0, 1'b1, 32'd100,        32'd7,          32'h0000_0002};
        vecs[2]  = '{1'b1, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        vecs[3]  = '{1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vecs[4]  = '{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
        vecs[5]  = '{1'b1, 1'b1, 32'd7,          32'hFFFF_FFFE,  32'h0000_0001};
        vecs[6]  = '{1'b0, 1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF};
        vecs[7]  = '{1'b0, 1'b1, 32'h1234_5678,  32'd0,          32'h1234_5678};
        vecs[8]  = '{1'b1, 1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF};
        vecs[9]  = '{1'b1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000};
        vecs[10] = '{1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[11] = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
        vecs[12] = '{1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[13] = '{1'b1, 1'b1, 32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFF8};
        vecs[14] = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'h0000_0010,  32'h0FFF_FFFF};

        // Reset state
        tick();
        tick();
        check("rst_busy", {31'd0, div_busy}, 32'd0);
        check("rst_done", {31'd0, div_done}, 32'd0);
        check("rst_result", div_result, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 15; i++) begin
            start_op(vecs[i].sgn, vecs[i].rem, vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), vecs[i].exp);
            ack_op();
        end

        // Cancel during BUSY cycle 10, with a request held alongside it
        start_op(1'b0, 1'b0, 32'd100, 32'd7);
        repeat (10) tick();
        div_cancel = 1'b1;
        div_req    = 1'b1;
        tick();
        div_cancel = 1'b0;
        div_req    = 1'b0;
        check("cancel_busy", {31'd0, div_busy}, 32'd0);
        check("cancel_done", {31'd0, div_done}, 32'd0);
        check("cancel_state", {30'd0, dbg_state}, 32'd0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (div_done || div_busy) seen_done++;
        end
        check("cancel_no_done", seen_done, 0);

        // Recovery request; ack held high during BUSY must not disturb it
        div_ack = 1'b1;
        start_op(1'b0, 1'b0, 32'd9, 32'd3);
        wait_done("after_cancel", 32'd3);
        tick();
        div_ack = 1'b0;
        check("ack_in_done_idle", {30'd0, dbg_state}, 32'd0);

        // Acknowledge stall with a second request held throughout
        div_signed = 1'b0;
        div_rem    = 1'b0;
        div_src1   = 32'd200;
        div_src2   = 32'd9;
        div_req    = 1'b1;
        tick();
        div_src1   = 32'd50;
        div_src2   = 32'd5;
        check("stall_accept", {31'd0, div_busy}, 32'd1);
        wait_done("stall", 32'h0000_0016);
        held = div_result;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall_done_%0d", i), {31'd0, div_done}, 32'd1);
            check($sformatf("stall_result_%0d", i), div_result, 32'h0000_0016);
        end
        div_ack = 1'b1;
        tick();
        div_ack = 1'b0;
        check("stall_ack_idle", {30'd0, dbg_state}, 32'd0);
        check("stall_ack_result_hold", div_result, held);
        tick();
        div_req = 1'b0;
        check("req_after_idle_busy", {31'd0, div_busy}, 32'd1);
        wait_done("held_req", 32'h0000_000A);
        ack_op();

        // Reset during BUSY cycle 20
        start_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
        repeat (20) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("midrst_busy", {31'd0, div_busy}, 32'd0);
        check("midrst_done", {31'd0, div_done}, 32'd0);
        check("midrst_result", div_result, 32'd0);
        start_op(1'b0, 1'b0, 32'd1000, 32'd10);
        wait_done("after_reset", 32'h0000_0064);
        ack_op();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exe_div_ctrl.md
EXE_DIV_CTRL -- requirements
Module: exe_div_ctrl

Interface
REQ-001 Parameters: none; the operand width is fixed at 32 bits.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 div_req  input  1  EXE holds a valid div/mod instruction; sampled only in IDLE.
REQ-005 div_signed  input  1  1 = signed (div.w/mod.w), 0 = unsigned (div.wu/mod.wu); sampled with div_req.
REQ-006 div_rem  input  1  1 = return remainder, 0 = return quotient; sampled with div_req.
REQ-007 div_src1  input  32  dividend; sampled with div_req.
REQ-008 div_src2  input  32  divisor; sampled with div_req.
REQ-009 div_ack  input  1  EXE result consumed (exe_mem_valid & mem_allowin); honoured only in DONE.
REQ-010 div_cancel  input  1  flush; aborts any operation in progress.
REQ-011 div_busy  output  1  high while the state is BUSY.
REQ-012 div_done  output  1  high while the state is DONE; EXE uses it as exe_ready_go for divide instructions.
REQ-013 div_result  output  32  selected quotient or remainder; valid while div_done = 1.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-015 IDLE -> BUSY on an edge with div_req=1 and div_cancel=0; at that edge operands, div_signed and div_rem are latched and the iteration counter is cleared to 0.
REQ-016 Operands: signed mode uses absolute values; unsigned mode uses raw values.
REQ-017 BUSY performs one restoring-division step per cycle, MSB first, for exactly 32 cycles; the counter is 6 bits wide and runs 0..31.
REQ-018 BUSY -> DONE on the edge where the counter equals 31; sign fix-up and quotient/remainder selection are applied at that edge and div_result is registered.
REQ-019 Latency: div_req is sampled at edge E0, and div_done first reads 1 after edge E32 (32 cycles later).
REQ-020 Sign rule: the quotient is negated when the operand signs differ; the remainder takes the sign of the dividend (signed mode only).
REQ-021 Divide by zero: quotient = 0xFFFFFFFF and remainder = dividend, in both modes; the operation still takes the full latency.
REQ-022 Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0x00000000.
REQ-023 DONE -> IDLE on an edge with div_ack=1; div_result holds its value until the next accepted request.
REQ-024 div_cancel=1 at any edge forces IDLE; cancel has priority over div_req and div_ack.
REQ-025 After a cancel, div_done is 0 in the next cycle and no stale result is ever flagged done.
REQ-026 div_req is ignored while in BUSY or DONE; div_ack is ignored while in IDLE or BUSY.
REQ-027 div_req=1 together with div_ack=1 in DONE: the block goes to IDLE and the request is accepted no earlier than the following edge.
REQ-028 Operand inputs may change after the accepting edge without affecting the operation in progress.

Reset
REQ-029 resetn=0 at an edge SHALL force the state to IDLE and clear the counter.
REQ-030 Reset values: div_busy=0, div_done=0, div_result=0x00000000.
REQ-031 Reset SHALL take effect mid-operation in BUSY or DONE with no partial result retained.
REQ-032 The first request after reset release SHALL be accepted normally.

Verification
REQ-033 Unsigned 100/7 with quotient selected -> after 32 cycles div_done=1 and div_result=0x0000000E; with div_rem=1 -> 0x00000002.
REQ-034 Signed -7/2 -> quotient 0xFFFFFFFD; remainder 0xFFFFFFFF. Signed 7/-2 -> quotient 0xFFFFFFFD; remainder 0x00000001.
REQ-035 Divide by zero: 0x12345678/0 -> quotient 0xFFFFFFFF, remainder 0x12345678; signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-036 Cancel at BUSY cycle 10 -> IDLE next cycle, div_busy=0, no div_done pulse; a new request of 9/3 then gives 0x00000003 at full latency.
REQ-037 div_ack held low for 5 cycles in DONE -> div_done and div_result stay stable; div_ack=1 -> IDLE; div_req asserted throughout is accepted on the edge after returning to IDLE.
REQ-038 resetn low during BUSY cycle 20 -> all outputs 0 after that edge; the next request completes correctly.
